// File: rtl/enc_sample_wr.sv
// enc_sample_wr: quadrature encoder capture stage that fills the sample SRAM.
// Each encoder edge produces one {dir, err, period} record, written to sequential
// addresses with a three-cycle SRAM write (SETUP, PULSE, HOLD). After DEPTH records
// the block parks in DONE and raises sample_end so the MCU readback stage can take over.
// Build option GLITCH_FILTER_EN: adds a 3-sample stability filter on each encoder channel.
module enc_sample_wr #(
    parameter logic [19:0]      DEPTH   = 20'h80000,
    parameter int               PER_W   = 14,
    parameter logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}}
) (
    input  logic             sample_clk,
    input  logic             rst_n,
    input  logic             sample_start,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [19:0]      mem_addr,
    output logic [PER_W+1:0] mem_data,
    output logic             mem_ce_n,
    output logic             mem_we_n,
    output logic             busy,
    output logic             sample_end,
    output logic             overrun
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_WAIT, ST_SETUP, ST_PULSE, ST_HOLD, ST_DONE
    } state_t;

    localparam logic [19:0] LAST_ADDR = DEPTH - 20'd1;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         start_sync;
    logic               start_d;
    logic [1:0]         a_sync;
    logic [1:0]         b_sync;
    logic               start_rise;
    logic [1:0]         cur_ab;
    logic [1:0]         prev_ab;
    logic [1:0]         ab_change;
    logic               edge_window;
    logic               enc_edge;
    logic               edge_err;
    logic               edge_dir;
    logic [PER_W+1:0]   edge_rec;
    logic               last_dir;
    logic [PER_W-1:0]   timer;
    logic [19:0]        wr_addr;
    logic [PER_W+1:0]   rec_q;
    logic [PER_W+1:0]   pend_q;
    logic               pend_v;
    logic               arm_req;
    logic               count_window;
    logic               last_slot;

    // Two-flop synchronisers for the asynchronous inputs plus start edge history
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= 2'b00;
            start_d    <= 1'b0;
            a_sync     <= 2'b00;
            b_sync     <= 2'b00;
        end else begin
            start_sync <= {start_sync[0], sample_start};
            start_d    <= start_sync[1];
            a_sync     <= {a_sync[0], enc_a};
            b_sync     <= {b_sync[0], enc_b};
        end
    end

    assign start_rise = start_sync[1] & ~start_d;

`ifdef GLITCH_FILTER_EN
    logic [1:0] a_hist;
    logic [1:0] b_hist;
    logic       a_hold;
    logic       b_hold;
    logic       a_use;
    logic       b_use;

    // A channel only moves once the synced sample agrees with the previous two
    always_comb begin
        a_use = (a_hist == {2{a_sync[1]}}) ? a_sync[1] : a_hold;
        b_use = (b_hist == {2{b_sync[1]}}) ? b_sync[1] : b_hold;
    end

    // Sample history and last accepted value for the stability filter
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hist <= 2'b00;
            b_hist <= 2'b00;
            a_hold <= 1'b0;
            b_hold <= 1'b0;
        end else begin
            a_hist <= {a_hist[0], a_sync[1]};
            b_hist <= {b_hist[0], b_sync[1]};
            a_hold <= a_use;
            b_hold <= b_use;
        end
    end

    assign cur_ab = {a_use, b_use};
`else
    assign cur_ab = {a_sync[1], b_sync[1]};
`endif

    assign edge_window  = (state == ST_WAIT) || (state == ST_SETUP) ||
                          (state == ST_PULSE) || (state == ST_HOLD);
    assign count_window = edge_window || (state == ST_ARM);
    assign ab_change    = cur_ab ^ prev_ab;
    assign enc_edge     = edge_window && (ab_change != 2'b00);
    assign edge_err     = (ab_change == 2'b11);
    assign edge_dir     = edge_err ? last_dir : (prev_ab[1] ^ cur_ab[0]);
    assign edge_rec     = {edge_dir, edge_err, timer};
    assign last_slot    = (wr_addr == LAST_ADDR);
    assign arm_req      = start_rise &&
                          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_WAIT));

    // State register
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: start re-arms only from idle, done or waiting
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_rise) state_nx = ST_ARM;
            ST_ARM:   state_nx = ST_WAIT;
            ST_WAIT: begin
                if (start_rise) begin
                    state_nx = ST_ARM;
                end else if (enc_edge || pend_v) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: state_nx = ST_PULSE;
            ST_PULSE: state_nx = ST_HOLD;
            ST_HOLD: begin
                if (last_slot) begin
                    state_nx = ST_DONE;
                end else if (pend_v || enc_edge) begin
                    state_nx = ST_SETUP;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Strobes and status decoded purely from state so reset releases them at once
    always_comb begin
        mem_ce_n   = 1'b1;
        mem_we_n   = 1'b1;
        busy       = 1'b0;
        sample_end = 1'b0;
        case (state)
            ST_ARM, ST_WAIT:   busy = 1'b1;
            ST_SETUP, ST_HOLD: begin
                busy     = 1'b1;
                mem_ce_n = 1'b0;
            end
            ST_PULSE: begin
                busy     = 1'b1;
                mem_ce_n = 1'b0;
                mem_we_n = 1'b0;
            end
            ST_DONE:           sample_end = 1'b1;
            default: ;
        endcase
    end

    // Interval timer, edge tracking, record staging, pending slot and write address
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= 20'd0;
            rec_q    <= '0;
            pend_q   <= '0;
            pend_v   <= 1'b0;
            timer    <= '0;
            prev_ab  <= 2'b00;
            last_dir <= 1'b0;
            overrun  <= 1'b0;
        end else if (arm_req) begin
            wr_addr <= 20'd0;
            overrun <= 1'b0;
            timer   <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (enc_edge) begin
                timer <= {{(PER_W-1){1'b0}}, 1'b1};
            end else if (count_window && (timer != PER_MAX)) begin
                timer <= timer + 1'b1;
            end

            if ((state == ST_ARM) || enc_edge) begin
                prev_ab <= cur_ab;
            end
            if (enc_edge) begin
                last_dir <= edge_dir;
            end

            case (state)
                ST_WAIT: begin
                    if (enc_edge) begin
                        rec_q <= edge_rec;
                    end
                end
                ST_SETUP, ST_PULSE: begin
                    if (enc_edge) begin
                        if (!pend_v) begin
                            pend_q <= edge_rec;
                            pend_v <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    wr_addr <= wr_addr + 20'd1;
                    if (last_slot) begin
                        pend_v <= 1'b0;
                    end else if (pend_v) begin
                        rec_q  <= pend_q;
                        pend_v <= 1'b0;
                        if (enc_edge) begin
                            overrun <= 1'b1;
                        end
                    end else if (enc_edge) begin
                        rec_q <= edge_rec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = wr_addr;
    assign mem_data = rec_q;

endmodule

// File: tb/tb_enc_sample_wr.sv
// tb_enc_sample_wr: directed, table-driven bench for enc_sample_wr built with DEPTH = 4.
`timescale 1ns/1ps
module tb_enc_sample_wr;

    localparam logic [19:0] DEPTH = 20'd4;

    logic        sample_clk = 1'b0;
    logic        rst_n;
    logic        sample_start;
    logic        enc_a;
    logic        enc_b;
    logic [19:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ce_n;
    logic        mem_we_n;
    logic        busy;
    logic        sample_end;
    logic        overrun;

    typedef struct {
        int          scen;
        logic [1:0]  ab;
        int          gap;
        bit          exp_wr;
        logic [19:0] addr;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  wr_q[$];
    wr_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    enc_sample_wr #(.DEPTH(DEPTH)) dut (
        .sample_clk   (sample_clk),
        .rst_n        (rst_n),
        .sample_start (sample_start),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ce_n     (mem_ce_n),
        .mem_we_n     (mem_we_n),
        .busy         (busy),
        .sample_end   (sample_end),
        .overrun      (overrun)
    );

    // Free-running capture clock
    always #5 sample_clk = ~sample_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input int gap);
        repeat (gap) @(negedge sample_clk);
        {enc_a, enc_b} = ab;
    endtask

    function automatic void addVec(input int scen, input logic [1:0] ab, input int gap,
                                   input bit exp_wr, input logic [19:0] addr,
                                   input logic [15:0] data);
        vec_t v;
        v.scen   = scen;
        v.ab     = ab;
        v.gap    = gap;
        v.exp_wr = exp_wr;
        v.addr   = addr;
        v.data   = data;
        vecs.push_back(v);
    endfunction

    // Record every SRAM write seen in the PULSE cycle; chip enable must be low with it
    always @(negedge sample_clk) begin
        if (rst_n && (mem_we_n === 1'b0)) begin
            wr_t w;
            w.addr = mem_addr;
            w.data = mem_data;
            wr_q.push_back(w);
            checkOutput("ce_with_we", {31'd0, mem_ce_n}, 32'd0);
        end
    end

    task automatic runScenario(input int s);
        wr_q.delete();
        exp_q.delete();
        @(negedge sample_clk);
        sample_start = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].scen == s) begin
                applyStimulus(vecs[i].ab, vecs[i].gap);
                sample_start = 1'b0;
                if (vecs[i].exp_wr) begin
                    wr_t e;
                    e.addr = vecs[i].addr;
                    e.data = vecs[i].data;
                    exp_q.push_back(e);
                end
            end
        end
        repeat (20) @(negedge sample_clk);
        checkOutput($sformatf("s%0d_wr_count", s), wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) begin
                checkOutput($sformatf("s%0d_wr%0d_addr", s, i), {12'd0, wr_q[i].addr}, {12'd0, exp_q[i].addr});
                checkOutput($sformatf("s%0d_wr%0d_data", s, i), {16'd0, wr_q[i].data}, {16'd0, exp_q[i].data});
            end
        end
    endtask

    initial begin
        bit found;

        // Forward steps 100 clks apart; first period is measured from ARM
        addVec(2, 2'b01,  10, 1'b1, 20'd0, 16'h8009);
        addVec(2, 2'b11, 100, 1'b1, 20'd1, 16'h8064);
        addVec(2, 2'b10, 100, 1'b1, 20'd2, 16'h8064);
        // Double change keeps the previous dir, then the reverse sequence fills DEPTH
        addVec(3, 2'b01,  10, 1'b1, 20'd0, 16'hC009);
        addVec(3, 2'b00,  50, 1'b1, 20'd1, 16'h0032);
        addVec(3, 2'b10,  50, 1'b1, 20'd2, 16'h0032);
        addVec(3, 2'b11,  50, 1'b1, 20'd3, 16'h0032);
        // Long silence saturates the period, next edge measures normally
        addVec(4, 2'b10, 20000, 1'b1, 20'd0, 16'hBFFF);
        addVec(4, 2'b00,    30, 1'b1, 20'd1, 16'h801E);
        // Three edges one clock apart: first written, second pending, third dropped
        addVec(5, 2'b10,  10, 1'b1, 20'd0, 16'h0009);
        addVec(5, 2'b11,   1, 1'b1, 20'd1, 16'h0001);
        addVec(5, 2'b01,   1, 1'b0, 20'd0, 16'h0000);
        // Six edges into a DEPTH of four: the last two are ignored in DONE
        addVec(6, 2'b11,  10, 1'b1, 20'd0, 16'h8009);
        addVec(6, 2'b10,  20, 1'b1, 20'd1, 16'h8014);
        addVec(6, 2'b00,  20, 1'b1, 20'd2, 16'h8014);
        addVec(6, 2'b01,  20, 1'b1, 20'd3, 16'h8014);
        addVec(6, 2'b11,  20, 1'b0, 20'd0, 16'h0000);
        addVec(6, 2'b10,  20, 1'b0, 20'd0, 16'h0000);

        rst_n        = 1'b0;
        sample_start = 1'b0;
        enc_a        = 1'b0;
        enc_b        = 1'b0;
        repeat (3) @(negedge sample_clk);
        checkOutput("rst_mem_addr",   {12'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_data",   {16'd0, mem_data}, 32'd0);
        checkOutput("rst_mem_ce_n",   {31'd0, mem_ce_n}, 32'd1);
        checkOutput("rst_mem_we_n",   {31'd0, mem_we_n}, 32'd1);
        checkOutput("rst_busy",       {31'd0, busy}, 32'd0);
        checkOutput("rst_sample_end", {31'd0, sample_end}, 32'd0);
        checkOutput("rst_overrun",    {31'd0, overrun}, 32'd0);
        @(negedge sample_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge sample_clk);

        // Reset asserted in the middle of a write pulse
        @(negedge sample_clk);
        sample_start = 1'b1;
        applyStimulus(2'b01, 10);
        sample_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge sample_clk);
            if (mem_we_n === 1'b0) found = 1'b1;
        end
        checkOutput("t1_pulse_seen", {31'd0, found}, 32'd1);
        checkOutput("t1_pulse_data", {16'd0, mem_data}, 32'h8009);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_we_n",       {31'd0, mem_we_n}, 32'd1);
        checkOutput("t1_ce_n",       {31'd0, mem_ce_n}, 32'd1);
        checkOutput("t1_sample_end", {31'd0, sample_end}, 32'd0);
        checkOutput("t1_busy",       {31'd0, busy}, 32'd0);
        checkOutput("t1_mem_addr",   {12'd0, mem_addr}, 32'd0);
        checkOutput("t1_mem_data",   {16'd0, mem_data}, 32'd0);
        repeat (2) @(negedge sample_clk);
        rst_n = 1'b1;
        {enc_a, enc_b} = 2'b00;
        repeat (10) @(negedge sample_clk);

        runScenario(2);
        checkOutput("s2_sample_end", {31'd0, sample_end}, 32'd0);
        checkOutput("s2_busy",       {31'd0, busy}, 32'd1);
        checkOutput("s2_overrun",    {31'd0, overrun}, 32'd0);

        runScenario(3);
        checkOutput("s3_sample_end", {31'd0, sample_end}, 32'd1);
        checkOutput("s3_busy",       {31'd0, busy}, 32'd0);

        runScenario(4);
        checkOutput("s4_sample_end", {31'd0, sample_end}, 32'd0);
        checkOutput("s4_busy",       {31'd0, busy}, 32'd1);

        runScenario(5);
        checkOutput("s5_overrun", {31'd0, overrun}, 32'd1);
        repeat (50) @(negedge sample_clk);
        checkOutput("s5_overrun_sticky", {31'd0, overrun}, 32'd1);

        runScenario(6);
        checkOutput("s6_overrun_cleared", {31'd0, overrun}, 32'd0);
        checkOutput("s6_sample_end",      {31'd0, sample_end}, 32'd1);
        checkOutput("s6_busy",            {31'd0, busy}, 32'd0);
        checkOutput("s6_ce_idle",         {31'd0, mem_ce_n}, 32'd1);

        // A new start from DONE drops sample_end and resumes capture
        @(negedge sample_clk);
        sample_start = 1'b1;
        repeat (6) @(negedge sample_clk);
        sample_start = 1'b0;
        checkOutput("restart_sample_end", {31'd0, sample_end}, 32'd0);
        checkOutput("restart_busy",       {31'd0, busy}, 32'd1);
        checkOutput("restart_addr",       {12'd0, mem_addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
